// File: rtl/dsp_cmd_pkg.sv
// ---------------------------------------------------------------------------
// dsp_cmd_pkg : opcodes, FSM states and timing defaults for dsp_cmd_loader
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dsp_cmd_pkg;

   localparam int unsigned SETUP_DEF     = 2;
   localparam int unsigned HOLD_DEF      = 4;
   localparam int unsigned GAP_DEF       = 2;
   localparam int unsigned INIT_WAIT_DEF = 512;

   localparam logic [7:0] OP_NOP   = 8'd0;
   localparam logic [7:0] OP_INIT  = 8'd1;
   localparam logic [7:0] OP_PUSH  = 8'd2;
   localparam logic [7:0] OP_START = 8'd3;
   localparam logic [7:0] OP_STOP  = 8'd4;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_COLLECT  = 3'd1,
      ST_SETUP    = 3'd2,
      ST_STROBE   = 3'd3,
      ST_GAP      = 3'd4,
      ST_INITWAIT = 3'd5
   } state_t;

   // Opcodes that carry no code bytes and go straight to the strobe sequence.
   function automatic logic is_direct_op(input logic [7:0] op);
      return (op == OP_INIT) || (op == OP_START) || (op == OP_STOP);
   endfunction

   function automatic int unsigned timer_width(input int unsigned a, input int unsigned b,
                                               input int unsigned c, input int unsigned d);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return $clog2(m + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/dsp_hold_timer.sv
// ---------------------------------------------------------------------------
// dsp_hold_timer : loadable down-counter; done_o is high on the last counted cycle
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dsp_hold_timer #(
   parameter int unsigned WIDTH = 10
) (
   input  logic             mclk,
   input  logic             reset_n,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   output logic             done_o
);

   logic [WIDTH-1:0] count_q;

   always_ff @(posedge mclk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else if (load_i) begin
         count_q <= load_val_i;
      end else if (count_q != '0) begin
         count_q <= count_q - WIDTH'(1);
      end
   end

   // A load of N yields N cycles of countdown, the Nth flagged as done.
   assign done_o = (count_q == WIDTH'(1));

endmodule

`default_nettype wire

// File: rtl/dsp_cmd_loader.sv
// ---------------------------------------------------------------------------
// dsp_cmd_loader : byte-stream command parser driving timed opcode strobes
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dsp_cmd_loader
   import dsp_cmd_pkg::*;
#(
   parameter int unsigned SETUP     = SETUP_DEF,
   parameter int unsigned HOLD      = HOLD_DEF,
   parameter int unsigned GAP       = GAP_DEF,
   parameter int unsigned INIT_WAIT = INIT_WAIT_DEF
) (
   input  logic        mclk,
   input  logic        reset_n,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [7:0]  sd0,
   output logic [7:0]  sd1,
   output logic [7:0]  sd2,
   output logic [7:0]  sd3,
   output logic [7:0]  sd4,
   output logic        busy,
   output logic        err,
   output logic [15:0] cmd_count
);

   localparam int unsigned TW = timer_width(SETUP, HOLD, GAP, INIT_WAIT);

   state_t      state_q;
   logic [7:0]  op_q;
   logic [1:0]  idx_q;
   logic [7:0]  sd0_q;
   logic [7:0]  sd_q [0:3];
   logic        busy_q;
   logic        in_ready_q;
   logic        err_q;
   logic [15:0] cmd_count_q;
   logic [15:0] cmd_count_d;

   logic          w_take;
   logic          w_tmr_load;
   logic [TW-1:0] w_tmr_val;
   logic          w_tmr_done;

   assign w_take = in_valid & in_ready_q;

   // The timer is (re)loaded on exactly the edges that enter a timed state.
   always_comb begin
      w_tmr_load = 1'b0;
      w_tmr_val  = '0;
      case (state_q)
         ST_IDLE: begin
            if (w_take && is_direct_op(in_data)) begin
               w_tmr_load = 1'b1;
               w_tmr_val  = TW'(SETUP);
            end
         end
         ST_COLLECT: begin
            if (w_take && (idx_q == 2'd3)) begin
               w_tmr_load = 1'b1;
               w_tmr_val  = TW'(SETUP);
            end
         end
         ST_SETUP: begin
            if (w_tmr_done) begin
               w_tmr_load = 1'b1;
               w_tmr_val  = TW'(HOLD);
            end
         end
         ST_STROBE: begin
            if (w_tmr_done) begin
               w_tmr_load = 1'b1;
               w_tmr_val  = TW'(GAP);
            end
         end
         ST_GAP: begin
            if (w_tmr_done && (op_q == OP_INIT)) begin
               w_tmr_load = 1'b1;
               w_tmr_val  = TW'(INIT_WAIT);
            end
         end
         default: ;
      endcase
   end

   assign cmd_count_d = cmd_count_q + {15'd0, (state_q == ST_SETUP) && w_tmr_done};

   dsp_hold_timer #(.WIDTH(TW)) u_timer (
      .mclk       (mclk),
      .reset_n    (reset_n),
      .load_i     (w_tmr_load),
      .load_val_i (w_tmr_val),
      .done_o     (w_tmr_done)
   );

   always_ff @(posedge mclk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         op_q        <= OP_NOP;
         idx_q       <= '0;
         sd0_q       <= '0;
         sd_q        <= '{default: 8'h00};
         busy_q      <= 1'b0;
         in_ready_q  <= 1'b0;
         err_q       <= 1'b0;
         cmd_count_q <= '0;
      end else begin
         cmd_count_q <= cmd_count_d;
         case (state_q)
            ST_IDLE: begin
               in_ready_q <= 1'b1;
               if (w_take) begin
                  if (in_data == OP_PUSH) begin
                     state_q <= ST_COLLECT;
                     op_q    <= in_data;
                     idx_q   <= '0;
                     busy_q  <= 1'b1;
                  end else if (is_direct_op(in_data)) begin
                     state_q    <= ST_SETUP;
                     op_q       <= in_data;
                     busy_q     <= 1'b1;
                     in_ready_q <= 1'b0;
                  end else if (in_data > OP_STOP) begin
                     err_q <= 1'b1;
                  end
               end
            end
            ST_COLLECT: begin
               if (w_take) begin
                  sd_q[idx_q] <= in_data;
                  idx_q       <= idx_q + 2'd1;
                  if (idx_q == 2'd3) begin
                     state_q    <= ST_SETUP;
                     in_ready_q <= 1'b0;
                  end
               end
            end
            ST_SETUP: begin
               if (w_tmr_done) begin
                  state_q <= ST_STROBE;
                  sd0_q   <= op_q;
               end
            end
            ST_STROBE: begin
               if (w_tmr_done) begin
                  state_q <= ST_GAP;
                  sd0_q   <= '0;
               end
            end
            ST_GAP: begin
               if (w_tmr_done) begin
                  if (op_q == OP_INIT) begin
                     state_q <= ST_INITWAIT;
                  end else begin
                     state_q    <= ST_IDLE;
                     busy_q     <= 1'b0;
                     in_ready_q <= 1'b1;
                     sd_q       <= '{default: 8'h00};
                  end
               end
            end
            ST_INITWAIT: begin
               if (w_tmr_done) begin
                  state_q    <= ST_IDLE;
                  busy_q     <= 1'b0;
                  in_ready_q <= 1'b1;
                  sd_q       <= '{default: 8'h00};
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign sd0       = sd0_q;
   assign sd1       = sd_q[0];
   assign sd2       = sd_q[1];
   assign sd3       = sd_q[2];
   assign sd4       = sd_q[3];
   assign busy      = busy_q;
   assign err       = err_q;
   assign cmd_count = cmd_count_q;

endmodule

`default_nettype wire

// File: tb/tb_dsp_cmd_loader.sv
// ---------------------------------------------------------------------------
// tb_dsp_cmd_loader : directed scenarios plus random traffic against a timeline model
// Revision          : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dsp_cmd_loader;

   localparam int S = 2;
   localparam int H = 4;
   localparam int G = 2;
   localparam int W = 512;

   logic        mclk = 1'b0;
   logic        reset_n = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  sd0, sd1, sd2, sd3, sd4;
   logic        busy;
   logic        err;
   logic [15:0] cmd_count;

   dsp_cmd_loader #(.SETUP(S), .HOLD(H), .GAP(G), .INIT_WAIT(W)) dut (
      .mclk      (mclk),
      .reset_n   (reset_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sd0       (sd0),
      .sd1       (sd1),
      .sd2       (sd2),
      .sd3       (sd3),
      .sd4       (sd4),
      .busy      (busy),
      .err       (err),
      .cmd_count (cmd_count)
   );

   always #5 mclk = ~mclk;

   int errors = 0;
   int checks = 0;

   // Reference model: command timeline expressed as edge timestamps.
   int          k = 0;
   bit          acc;
   bit          m_inflight, m_collecting, m_ready, m_err;
   int          m_n, m_t, m_idle_at;
   logic [7:0]  m_op;
   logic [31:0] m_code;
   logic [15:0] m_cnt;

   function automatic logic [7:0] exp_sd0();
      return (m_inflight && k >= m_t + S && k < m_t + S + H) ? m_op : 8'h00;
   endfunction

   task automatic model_reset();
      m_inflight = 0; m_collecting = 0; m_ready = 0; m_err = 0;
      m_n = 0; m_op = 8'h00; m_code = 32'h0; m_cnt = 16'h0;
   endtask

   task automatic launch(input logic [7:0] op);
      m_inflight = 1;
      m_op       = op;
      m_t        = k;
      m_idle_at  = k + S + H + G + ((op == 8'd1) ? W : 0);
   endtask

   task automatic step(input logic v, input logic [7:0] d);
      in_valid = v;
      in_data  = d;
      acc      = v && m_ready;
      @(posedge mclk);
      k++;
      if (m_inflight && k == m_t + S) m_cnt = m_cnt + 16'd1;
      if (m_inflight && k == m_idle_at) begin
         m_inflight = 0;
         m_code     = 32'h0;
      end
      if (acc) begin
         if (m_collecting) begin
            m_code[31 - 8*m_n -: 8] = d;
            m_n++;
            if (m_n == 4) begin
               m_collecting = 0;
               launch(8'd2);
            end
         end else if (d == 8'd2) begin
            m_collecting = 1;
            m_n = 0;
         end else if (d == 8'd1 || d == 8'd3 || d == 8'd4) begin
            launch(d);
         end else if (d > 8'd4) begin
            m_err = 1;
         end
      end
      m_ready = !m_inflight;
      @(negedge mclk);
      in_valid = 1'b0;
   endtask

   task automatic send(input logic [7:0] b);
      int n = 0;
      step(1'b1, b);
      while (!acc && n < 1000) begin
         step(1'b1, b);
         n++;
      end
      checks++;
      if (!acc) begin
         errors++;
         $display("FAIL send_timeout: byte %h not taken, in_ready=%b, required acceptance within 1000 cycles", b, in_ready);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      model_reset();
      repeat (3) @(negedge mclk);
      checks += 6;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
      if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
      if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err); end
      if (sd0 !== 8'h00) begin errors++; $display("FAIL rst_sd0: got %h want 00", sd0); end
      if ({sd1, sd2, sd3, sd4} !== 32'h0) begin errors++; $display("FAIL rst_sd: got %h want 0", {sd1, sd2, sd3, sd4}); end
      if (cmd_count !== 16'h0) begin errors++; $display("FAIL rst_count: got %h want 0000", cmd_count); end
      reset_n = 1'b1;
      step(1'b0, 8'h00);
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_push();
      int n_s = 0, first_s = -1, first_idle = -1, bad_hold = 0;
      send(8'h02); send(8'h3F); send(8'hFF); send(8'h01); send(8'hA1);
      checks += 2;
      if ({sd1, sd2, sd3, sd4} !== 32'h3FFF01A1) begin errors++; $display("FAIL push_code: got %h want 3fff01a1", {sd1, sd2, sd3, sd4}); end
      if (sd0 !== 8'h00) begin errors++; $display("FAIL push_sd0_setup: got %h want 00", sd0); end
      for (int j = 1; j <= 12; j++) begin
         step(1'b0, 8'h00);
         if (sd0 == 8'h02) begin n_s++; if (first_s < 0) first_s = j; end
         if (!busy && first_idle < 0) first_idle = j;
         if (busy && {sd1, sd2, sd3, sd4} != 32'h3FFF01A1) bad_hold++;
      end
      checks += 6;
      if (n_s != H) begin errors++; $display("FAIL push_strobe_len: got %0d want %0d", n_s, H); end
      if (first_s != S) begin errors++; $display("FAIL push_strobe_start: got %0d want %0d", first_s, S); end
      if (first_idle != S + H + G) begin errors++; $display("FAIL push_busy_fall: got %0d want %0d", first_idle, S + H + G); end
      if (bad_hold != 0) begin errors++; $display("FAIL push_code_hold: got %0d bad cycles want 0", bad_hold); end
      if (cmd_count !== 16'd1) begin errors++; $display("FAIL push_count: got %h want 0001", cmd_count); end
      if ({sd1, sd2, sd3, sd4} !== 32'h0) begin errors++; $display("FAIL push_idle_clear: got %h want 0", {sd1, sd2, sd3, sd4}); end
   endtask

   task automatic test_init();
      int n_busy, n_s1 = 0, n_s3 = 0, acc_j = -1;
      send(8'h01);
      n_busy = (busy === 1'b1 && in_ready === 1'b0) ? 1 : 0;
      for (int j = 1; j <= 600; j++) begin
         step(1'b1, 8'h03);
         if (acc) begin acc_j = j; break; end
         if (busy && !in_ready) n_busy++;
         if (sd0 == 8'h01) n_s1++;
      end
      for (int j = 0; j < 12; j++) begin
         step(1'b0, 8'h00);
         if (sd0 == 8'h03) n_s3++;
      end
      checks += 5;
      if (n_busy != S + H + G + W) begin errors++; $display("FAIL init_busy_len: got %0d want %0d", n_busy, S + H + G + W); end
      if (n_s1 != H) begin errors++; $display("FAIL init_strobe_len: got %0d want %0d", n_s1, H); end
      if (acc_j != S + H + G + W + 1) begin errors++; $display("FAIL init_held_byte_accept: got cycle %0d want %0d", acc_j, S + H + G + W + 1); end
      if (n_s3 != H) begin errors++; $display("FAIL init_held_byte_strobe: got %0d want %0d", n_s3, H); end
      if (cmd_count !== 16'd3) begin errors++; $display("FAIL init_count: got %h want 0003", cmd_count); end
   endtask

   task automatic test_bad();
      int n_s3 = 0, err_drop = 0;
      send(8'h07);
      checks += 4;
      if (err !== 1'b1) begin errors++; $display("FAIL bad_err_set: got %b want 1", err); end
      if (sd0 !== 8'h00) begin errors++; $display("FAIL bad_sd0: got %h want 00", sd0); end
      if (busy !== 1'b0) begin errors++; $display("FAIL bad_busy: got %b want 0", busy); end
      if (in_ready !== 1'b1) begin errors++; $display("FAIL bad_ready: got %b want 1", in_ready); end
      send(8'h03);
      for (int j = 0; j < 12; j++) begin
         step(1'b0, 8'h00);
         if (sd0 == 8'h03) n_s3++;
         if (err !== 1'b1) err_drop++;
      end
      checks += 3;
      if (n_s3 != H) begin errors++; $display("FAIL bad_then_start: got %0d want %0d", n_s3, H); end
      if (err_drop != 0) begin errors++; $display("FAIL bad_err_sticky: got %0d cleared cycles want 0", err_drop); end
      if (cmd_count !== 16'd4) begin errors++; $display("FAIL bad_count: got %h want 0004", cmd_count); end
   endtask

   task automatic test_reset_abort();
      int n_ghost = 0, n_s = 0;
      send(8'h02); send(8'h00); send(8'h00);
      reset_n = 1'b0;
      #1;
      checks += 3;
      if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
      if (in_ready !== 1'b0) begin errors++; $display("FAIL abort_ready: got %b want 0", in_ready); end
      if ({sd0, sd1, sd2, sd3, sd4} !== 40'h0) begin errors++; $display("FAIL abort_sd: got %h want 0", {sd0, sd1, sd2, sd3, sd4}); end
      model_reset();
      repeat (3) @(posedge mclk);
      @(negedge mclk);
      reset_n = 1'b1;
      for (int j = 0; j < 8; j++) begin
         step(1'b0, 8'h00);
         if (sd0 != 8'h00 || busy) n_ghost++;
      end
      send(8'h02); send(8'h00); send(8'h00); send(8'h02); send(8'h45);
      checks += 2;
      if (n_ghost != 0) begin errors++; $display("FAIL abort_no_strobe: got %0d active cycles want 0", n_ghost); end
      if ({sd1, sd2, sd3, sd4} !== 32'h00000245) begin errors++; $display("FAIL abort_code: got %h want 00000245", {sd1, sd2, sd3, sd4}); end
      for (int j = 0; j < 12; j++) begin
         step(1'b0, 8'h00);
         if (sd0 == 8'h02) n_s++;
      end
      checks += 2;
      if (n_s != H) begin errors++; $display("FAIL abort_strobe: got %0d want %0d", n_s, H); end
      if (cmd_count !== 16'd1) begin errors++; $display("FAIL abort_count: got %h want 0001", cmd_count); end
   endtask

   task automatic test_wrap();
      int n_s = 0;
      force dut.cmd_count_q = 16'hFFFF;
      step(1'b0, 8'h00);
      step(1'b0, 8'h00);
      release dut.cmd_count_q;
      m_cnt = 16'hFFFF;
      step(1'b0, 8'h00);
      checks++;
      if (cmd_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload: got %h want ffff", cmd_count); end
      send(8'h04);
      for (int j = 0; j < 12; j++) begin
         step(1'b0, 8'h00);
         if (sd0 == 8'h04) n_s++;
      end
      checks += 2;
      if (n_s != H) begin errors++; $display("FAIL wrap_strobe: got %0d want %0d", n_s, H); end
      if (cmd_count !== 16'h0000) begin errors++; $display("FAIL wrap_count: got %h want 0000", cmd_count); end
   endtask

   task automatic test_nop();
      int bad = 0;
      send(8'h00);
      checks += 3;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL nop_ready: got %b want 1", in_ready); end
      if (busy !== 1'b0) begin errors++; $display("FAIL nop_busy: got %b want 0", busy); end
      if (sd0 !== 8'h00) begin errors++; $display("FAIL nop_sd0: got %h want 00", sd0); end
      for (int j = 0; j < 6; j++) begin
         step(1'b0, 8'h00);
         if (!in_ready || busy || sd0 != 8'h00) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL nop_quiet: got %0d active cycles want 0", bad); end
   endtask

   task automatic test_random();
      logic       v;
      logic [7:0] d;
      int         r;
      for (int i = 0; i < 3000; i++) begin
         v = ($urandom_range(0, 3) != 0);
         if (m_collecting) begin
            d = 8'($urandom_range(0, 255));
         end else begin
            r = $urandom_range(0, 99);
            d = (r < 4)  ? 8'd1 : (r < 30) ? 8'd2 : (r < 50) ? 8'd3 :
                (r < 70) ? 8'd4 : (r < 80) ? 8'd0 : 8'($urandom_range(5, 255));
         end
         step(v, d);
         checks += 6;
         if (sd0 !== exp_sd0()) begin errors++; $display("FAIL rnd_sd0 @%0d: got %h want %h", k, sd0, exp_sd0()); end
         if ({sd1, sd2, sd3, sd4} !== m_code) begin errors++; $display("FAIL rnd_code @%0d: got %h want %h", k, {sd1, sd2, sd3, sd4}, m_code); end
         if (busy !== (m_inflight || m_collecting)) begin errors++; $display("FAIL rnd_busy @%0d: got %b want %b", k, busy, m_inflight || m_collecting); end
         if (in_ready !== m_ready) begin errors++; $display("FAIL rnd_ready @%0d: got %b want %b", k, in_ready, m_ready); end
         if (err !== m_err) begin errors++; $display("FAIL rnd_err @%0d: got %b want %b", k, err, m_err); end
         if (cmd_count !== m_cnt) begin errors++; $display("FAIL rnd_count @%0d: got %h want %h", k, cmd_count, m_cnt); end
      end
   endtask

   initial begin
      test_reset();
      test_push();
      test_init();
      test_bad();
      test_reset_abort();
      test_wrap();
      test_nop();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running at time %0t, required completion earlier", $time);
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire

// File: doc/dsp_cmd_loader.md
DSP_CMD_LOADER -- requirements
Module: dsp_cmd_loader

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- SETUP, 2, mclk cycles code is stable before strobe.
- HOLD, 4, mclk cycles sd0 carries a nonzero opcode.
- GAP, 2, mclk cycles of sd0=0 after strobe, code still held.
- INIT_WAIT, 512, extra busy cycles after INIT.
REQ-002 Ports, one per line: name, direction, width, meaning.
- mclk, in, 1, clock.
- reset_n, in, 1, reset, asynchronous, active-low.
- in_data, in, 8, byte stream from host link.
- in_valid, in, 1, in_data valid.
- in_ready, out, 1, byte accepted on the same cycle when in_valid=1.
- sd0, out, 8, opcode to the DSP core.
- sd1..sd4, out, 8 each, code[31:24]..code[7:0].
- busy, out, 1, a command is in flight.
- err, out, 1, sticky bad-opcode flag.
- cmd_count, out, 16, count of issued commands.

Function
REQ-003 The block SHALL recognise these opcodes: 0 NOP, 1 INIT, 2 PUSH, 3 START, 4 STOP.
REQ-004 States SHALL be IDLE, COLLECT, SETUP, STROBE, GAP and INITWAIT.
REQ-005 in_ready SHALL be 1 only in IDLE and COLLECT.
REQ-006 A byte SHALL be consumed only on a cycle with in_valid=1 and in_ready=1; an unconsumed byte is neither dropped nor duplicated.
REQ-007 Opcode accepted in IDLE:
- PUSH goes to COLLECT.
- Opcodes 1, 3 and 4 go to SETUP with code=0.
- 0 is discarded; the state stays IDLE and nothing is emitted.
REQ-008 An opcode >4 SHALL be discarded, SHALL set err=1 on the next edge, and the state SHALL stay IDLE.
REQ-009 COLLECT SHALL accept exactly 4 bytes, MSB first, then go to SETUP.
REQ-010 sd1..sd4 SHALL update on the edge that consumes each byte.
REQ-011 SETUP SHALL last SETUP cycles with sd0=0.
REQ-012 STROBE SHALL last HOLD cycles with sd0=opcode.
REQ-013 GAP SHALL last GAP cycles with sd0=0; after GAP:
- INIT goes to INITWAIT.
- All other opcodes go to IDLE.
REQ-014 INITWAIT SHALL last INIT_WAIT cycles, then go to IDLE.
REQ-015 sd1..sd4 SHALL hold their value through SETUP, STROBE and GAP.
REQ-016 sd1..sd4 SHALL return to 0 on entry to IDLE.
REQ-017 busy SHALL be 1 in every state except IDLE.
REQ-018 cmd_count SHALL increment by 1 on the first STROBE cycle and SHALL wrap from FFFF to 0000.
REQ-019 Timing for a PUSH: with the last code byte consumed at edge t, sd0 SHALL equal 2 during edges t+SETUP+1 .. t+SETUP+HOLD.
REQ-020 A stall of in_valid during COLLECT SHALL wait indefinitely; there is no timeout.
REQ-021 err SHALL clear only on reset.

Reset
REQ-022 On reset_n=0 the block SHALL asynchronously force:
- state IDLE;
- sd0..sd4=0, busy=0, err=0, cmd_count=0;
- in_ready=0 while reset is asserted, 1 from the first edge after release.
REQ-023 Reset during any state SHALL abort the command with no partial strobe afterwards; partial COLLECT bytes SHALL be discarded.

Structure
REQ-024 Shared package dsp_cmd_pkg SHALL hold:
- the opcode constants;
- the state enumeration;
- the default values of SETUP, HOLD, GAP and INIT_WAIT.
REQ-025 One sub-module, dsp_hold_timer, SHALL implement a loadable down-counter with a done pulse, wide enough for INIT_WAIT; it is shared by SETUP, STROBE, GAP and INITWAIT.

Verification
REQ-026 Benches SHALL cover these directed scenarios:
- Bytes 02 3F FF 01 A1 -> sd1..sd4=3F FF 01 A1; sd0=02 for exactly 4 cycles after 2 setup cycles; cmd_count=1; busy falls 2 cycles after strobe ends.
- Byte 01 -> sd0=01 for 4 cycles; busy=1 and in_ready=0 for 2+4+2+512 cycles; an in_valid byte offered meanwhile is held, then accepted once IDLE is reached.
- Bytes 07 then 03 -> err=1 after 07 with sd0=0; the 03 still strobes sd0=03 for 4 cycles; err remains 1.
- Bytes 02 00 00 then reset_n low for 3 cycles, then 02 00 00 02 45 -> no strobe before reset; after it, sd1..sd4=00 00 02 45 and sd0=02 strobes.
- Preload cmd_count to FFFF, then send 04 -> cmd_count=0000 and sd0=04 for 4 cycles.
- Byte 00 -> in_ready stays 1, busy stays 0, sd0 stays 0.
